// File: rtl/multicycle_ctrl_if.sv
// ============================================================================
// Module      : multicycle_ctrl_if
// Description : Opcode/status inputs and datapath control strobes of the
//               multicycle controller, grouped with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_ctrl_if;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [3:0] state;
    logic       instr_done;

    // Master is the datapath/memory side; slave is the controller.
    modport master (
        output op, zero, mem_ready,
        input  pc_write, ir_write, adr_src, mem_write, reg_write,
        input  result_src, alu_src_a, alu_src_b, alu_op, state, instr_done
    );

    modport slave (
        input  op, zero, mem_ready,
        output pc_write, ir_write, adr_src, mem_write, reg_write,
        output result_src, alu_src_a, alu_src_b, alu_op, state, instr_done
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module      : multicycle_ctrl
// Description : Moore control FSM for a multicycle RV32 subset datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl (
    input  wire logic         clk,
    input  wire logic         reset,
    multicycle_ctrl_if.slave  bus
);

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        ALUWB    = 4'd7,
        EXECUTEI = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } state_t;

    // Pure state-decoded controls plus flags that qualify the input-dependent
    // strobes (pc_write, ir_write, instr_done) against mem_ready/zero.
    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       in_fetch;
        logic       in_beq;
        logic       in_jal;
        logic       done;
    } ctrl_t;

    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
                c.in_fetch   = 1'b1;
            end
            DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            MEMREAD: begin
                c.adr_src = 1'b1;
            end
            MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
                c.done       = 1'b1;
            end
            MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            EXECUTER: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            ALUWB: begin
                c.reg_write = 1'b1;
                c.done      = 1'b1;
            end
            EXECUTEI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.in_jal    = 1'b1;
            end
            BEQ: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b01;
                c.in_beq    = 1'b1;
                c.done      = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t state_q;
    state_t next_state;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl_out;

    always_comb begin
        next_state = FETCH;
        case (state_q)
            FETCH:    next_state = bus.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECUTER;
                    OP_ITYPE:     next_state = EXECUTEI;
                    OP_BEQ:       next_state = BEQ;
                    OP_JAL:       next_state = JAL;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR:   next_state = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  next_state = bus.mem_ready ? MEMWB : MEMREAD;
            MEMWRITE: next_state = bus.mem_ready ? FETCH : MEMWRITE;
            EXECUTER: next_state = ALUWB;
            EXECUTEI: next_state = ALUWB;
            JAL:      next_state = ALUWB;
            default:  next_state = FETCH;
        endcase
    end

    // Controls are registered alongside the state by decoding the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            ctrl_q  <= decode(FETCH);
        end else begin
            state_q <= next_state;
            ctrl_q  <= decode(next_state);
        end
    end

    // While reset is held the datapath sees FETCH selects with every strobe
    // suppressed, even in the cycle before the reset edge lands.
    always_comb begin
        ctrl_out = reset ? decode(FETCH) : ctrl_q;
    end

    assign bus.adr_src    = ctrl_out.adr_src;
    assign bus.mem_write  = ctrl_out.mem_write;
    assign bus.reg_write  = ctrl_out.reg_write;
    assign bus.result_src = ctrl_out.result_src;
    assign bus.alu_src_a  = ctrl_out.alu_src_a;
    assign bus.alu_src_b  = ctrl_out.alu_src_b;
    assign bus.alu_op     = ctrl_out.alu_op;
    assign bus.ir_write   = ~reset & ctrl_out.in_fetch & bus.mem_ready;
    assign bus.pc_write   = ~reset & ((ctrl_out.in_fetch & bus.mem_ready) |
                                      (ctrl_out.in_beq & bus.zero) |
                                      ctrl_out.in_jal);
    assign bus.instr_done = ~reset & (ctrl_out.done |
                                      (ctrl_out.mem_write & bus.mem_ready));
    assign bus.state      = state_q;

endmodule

`default_nettype wire
